// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam int unsigned InstrBytes = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head.
// A full FIFO may push and pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    push_i,
  input  logic [Width-1:0]        data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [Width-1:0]        head_o,
  output logic [$clog2(Depth):0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Depth is a power of two, so the pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding imem request, PC-tagged
// instruction buffer towards decode, flush-and-restart on redirect.
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          AddrWidth    = 32,
  parameter int unsigned          InstrWidth   = 32,
  parameter int unsigned          FifoDepth    = 2,
  parameter logic [AddrWidth-1:0] StartAddress = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  redirect_i,
  input  logic [AddrWidth-1:0]  redirect_pc_i,
  output logic                  imem_req_o,
  output logic [AddrWidth-1:0]  imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [InstrWidth-1:0] imem_rdata_i,
  output logic [InstrWidth-1:0] instr_o,
  output logic [AddrWidth-1:0]  instr_pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i
);

  localparam int unsigned EntryW = InstrWidth + AddrWidth;
  localparam int unsigned CntW   = $clog2(FifoDepth) + 1;

  fetch_state_e          state_q, state_d;
  logic [AddrWidth-1:0]  fetch_addr_q, fetch_addr_d;
  logic [AddrWidth-1:0]  tag_pc_q, tag_pc_d;
  logic [AddrWidth-1:0]  redirect_addr;
  logic                  unused_redirect_lsb;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EntryW-1:0]     fifo_head;
  logic [CntW-1:0]       fifo_count;
  logic                  wait_space;

  assign redirect_addr       = {redirect_pc_i[AddrWidth-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = imem_req_o ? fetch_addr_q : '0;

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_head[EntryW-1:AddrWidth];
  assign instr_pc_o    = fifo_head[AddrWidth-1:0];
  assign fifo_pop      = instr_valid_o && instr_ready_i;

  // Occupancy after this cycle's push and any concurrent pop by decode.
  assign wait_space = ((32'(fifo_count) + 32'd1 - 32'(fifo_pop)) < FifoDepth);

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    tag_pc_d     = tag_pc_q;
    fifo_push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect_i && !fifo_full) state_d = REQ;
      end
      REQ: begin
        if (imem_gnt_i) begin
          tag_pc_d     = fetch_addr_q;
          fetch_addr_d = fetch_addr_q + AddrWidth'(InstrBytes);
          state_d      = redirect_i ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_i) begin
            state_d = REQ;
          end else begin
            fifo_push = 1'b1;
            state_d   = wait_space ? REQ : IDLE;
          end
        end else if (redirect_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) fetch_addr_d = redirect_addr;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= {StartAddress[AddrWidth-1:2], 2'b00};
      tag_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      tag_pc_q     <= tag_pc_d;
    end
  end

  fetch_fifo #(
    .Width (EntryW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (fifo_push),
    .data_i  ({imem_rdata_i, tag_pc_q}),
    .pop_i   (fifo_pop),
    .flush_i (redirect_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

`ifdef SIM
  // Responses are only legal while a granted request is outstanding.
  assert property (@(posedge clk_i) disable iff (!rstn_i)
                   imem_rvalid_i |-> (state_q == WAIT || state_q == DROP));
`endif

endmodule
